muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 SHALL have parameter UNROLL, default 1, giving iteration steps per clock; legal values are 1, 2 and 4, and each SHALL divide XLEN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a new operation.
REQ-006 SHALL have port op, input, 3 bits: operation code in RV32M funct3 encoding (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-007 SHALL have port in1, input, XLEN bits: rs1 operand (multiplicand/dividend).
REQ-008 SHALL have port in2, input, XLEN bits: rs2 operand (multiplier/divisor).
REQ-009 SHALL have port abort, input, 1 bit: cancel any operation in flight.
REQ-010 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-012 SHALL have port result, output, XLEN bits: registered result.

Function
REQ-013 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE, start=1 SHALL capture op, in1 and in2 and enter CALC, except in the special cases of REQ-019 and REQ-020, which enter FIX directly.
REQ-015 start SHALL be ignored in every state other than IDLE; the captured operands SHALL NOT change until the unit returns to IDLE.
REQ-016 CALC SHALL run exactly XLEN/UNROLL cycles, using radix-2 shift-add for multiply and restoring division on operand magnitudes for divide.
REQ-017 FIX SHALL take one cycle to apply sign correction and to select the result:
  - MUL selects the low product half; MULH/MULHSU/MULHU select the high half.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
REQ-018 Signedness SHALL be:
  - MULH: both operands signed.
  - MULHSU: in1 signed, in2 unsigned.
  - DIV/REM: both signed; the remainder takes the sign of the dividend.
  - All other operations: unsigned.
REQ-019 Divide by zero SHALL give quotient all-ones and remainder = in1, for both signed and unsigned division.
REQ-020 Signed overflow (in1 = most-negative, in2 = -1) SHALL give quotient = in1 and remainder = 0.
REQ-021 DONE SHALL last one cycle: the state is DONE if and only if done=1, and the next state is IDLE.
REQ-022 Normal latency SHALL be XLEN/UNROLL+2 cycles from the start edge to done, i.e. 34 cycles for XLEN=32, UNROLL=1.
REQ-023 Special-case latency (REQ-019, REQ-020) SHALL be 2 cycles from start to done.
REQ-024 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-025 A new start SHALL be accepted in the cycle after done.
REQ-026 result SHALL hold its value from the done cycle until the next done.
REQ-027 abort=1 SHALL force IDLE on the next edge from any state, with no done pulse and result unchanged.
REQ-028 abort SHALL win over a simultaneous start.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, busy=0, done=0 and result=0, and SHALL clear all internal accumulators and counters.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow its release.
REQ-031 The first start SHALL be honoured on the first rising clk edge after reset deasserts.

Structure
REQ-032 A shared package muldiv_pkg SHALL hold:
  - the op enum (funct3 values);
  - the state enum;
  - the constants for the legal UNROLL set.
REQ-033 Sub-module muldiv_step SHALL implement one multiply or divide iteration and SHALL be instantiated UNROLL times in a chain.
REQ-034 The iteration counter SHALL be clog2(XLEN/UNROLL)+1 bits wide.
REQ-035 A single 2*XLEN accumulator SHALL be shared by multiply and divide.

Verification
REQ-036 MUL, in1=7, in2=0xFFFFFFFD (-3) -> result=0xFFFFFFEB, with done exactly 34 cycles after start (XLEN=32, UNROLL=1).
REQ-037 MULH and MULHU, in1=in2=0x80000000 -> MULH gives 0x40000000, MULHU gives 0x40000000; MULHSU with in1=0xFFFFFFFF, in2=2 -> 0xFFFFFFFF.
REQ-038 DIV and REM, in1=0xFFFFFFF9 (-7), in2=2 -> DIV gives 0xFFFFFFFD, REM gives 0xFFFFFFFF; DIVU and REMU, in1=100, in2=7 -> 14 and 2.
REQ-039 Special cases -> DIVU by 0 gives 0xFFFFFFFF and REM 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0; each with done 2 cycles after start.
REQ-040 Abort and reset -> abort at CALC cycle 10 returns to IDLE with busy=0 next cycle, no done, and result unchanged; reset=0 mid-CALC clears busy, done and result immediately; start held high during busy does not restart the operation.
REQ-041 The bench SHALL repeat REQ-036 to REQ-039 for UNROLL=2 (latency 18) and UNROLL=4 (latency 10), and SHALL run a 10k-operation random comparison against a reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and helpers for the iterative multiply/divide unit.
//   op_e      : operation code, RV32M funct3 encoding
//   state_e   : control FSM states
//   UNROLL_*  : the legal iteration-steps-per-clock values
//   legal_steps()    : steps per clock actually built for a given XLEN/UNROLL
//   op_is_div()      : operation uses the divider path
//   op_rs1_signed()  : in1 is interpreted as two's complement
//   op_rs2_signed()  : in2 is interpreted as two's complement
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int UNROLL_1 = 1;
  localparam int UNROLL_2 = 2;
  localparam int UNROLL_4 = 4;

  // An unsupported UNROLL (or one that does not divide XLEN) falls back to a
  // single step per clock so the unit still produces correct results.
  function automatic int legal_steps(input int xlen, input int unroll);
    if ((unroll == UNROLL_1 || unroll == UNROLL_2 || unroll == UNROLL_4) &&
        (xlen % unroll == 0)) begin
      return unroll;
    end
    return UNROLL_1;
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_rs1_signed(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_rs2_signed(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration on the shared 2*XLEN accumulator.
//   i_is_div : 1 = restoring-division step, 0 = shift-add multiply step
//   i_opnd   : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   i_acc    : accumulator before the step
//   o_acc    : accumulator after the step
// Multiply layout : {partial product high, remaining multiplier bits}
// Divide layout   : {partial remainder, dividend bits / quotient bits}
// -----------------------------------------------------------------------------
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier LSB is set;
    // the carry out becomes the new MSB after the right shift.
    w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} +
            (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});

    // Divide: remainder shifted left with the next dividend bit. It needs one
    // extra bit because the remainder can be as large as divisor-1.
    w_rem_shift = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_fits      = (w_rem_shift >= {1'b0, i_opnd});
    // The difference is < divisor when it is used, so XLEN bits suffice.
    w_diff      = w_rem_shift[XLEN-1:0] - i_opnd;

    if (i_is_div) begin
      if (w_fits) begin
        o_acc = {w_diff, i_acc[XLEN-2:0], 1'b1};
      end else begin
        o_acc = {w_rem_shift[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M-style multiply/divide unit. Operands are converted to
// magnitudes on capture, iterated XLEN/UNROLL cycles through a chain of
// UNROLL muldiv_step instances, then sign-corrected in a single FIX cycle.
// Divide-by-zero and signed overflow skip CALC and go straight to FIX.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous reset, active low
//   start  : request a new operation (honoured in IDLE only)
//   op     : funct3 operation code
//   in1    : rs1 operand (multiplicand / dividend)
//   in2    : rs2 operand (multiplier / divisor)
//   abort  : cancel any operation, return to IDLE, no done, result kept
//   busy   : high in CALC and FIX
//   done   : one-cycle pulse, high exactly while in DONE
//   result : registered result, held until the next done
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = legal_steps(XLEN, UNROLL);
  localparam int ITERS = XLEN / STEPS;
  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e            r_state;
  op_e               r_op;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_main;  // negate product / quotient in FIX
  logic              r_neg_rem;   // negate remainder in FIX
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  // ---------------------------------------------------------------------------
  // Operand decode at capture time
  // ---------------------------------------------------------------------------
  op_e             w_op;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;

  always_comb begin
    w_op       = op_e'(op);
    w_neg_a    = op_rs1_signed(w_op) && in1[XLEN-1];
    w_neg_b    = op_rs2_signed(w_op) && in2[XLEN-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    w_mag_a    = w_neg_a ? -in1 : in1;
    w_mag_b    = w_neg_b ? -in2 : in2;
    w_div_zero = op_is_div(w_op) && (in2 == '0);
    w_div_ovf  = (w_op == OP_DIV || w_op == OP_REM) &&
                 (in1 == MOST_NEG) && (in2 == {XLEN{1'b1}});
  end

  // ---------------------------------------------------------------------------
  // Iteration chain
  // ---------------------------------------------------------------------------
  logic              w_is_div;
  logic [2*XLEN-1:0] w_chain [0:STEPS];

  assign w_is_div   = op_is_div(r_op);
  assign w_chain[0] = r_acc;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    muldiv_step #(
      .XLEN (XLEN)
    ) u_step (
      .i_is_div (w_is_div),
      .i_opnd   (r_opnd),
      .i_acc    (w_chain[gi]),
      .o_acc    (w_chain[gi+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Sign correction and result selection (used in FIX)
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_result;

  always_comb begin
    w_prod = r_neg_main ? -r_acc : r_acc;
    w_quo  = r_neg_main ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_fix_result = w_rem;
    case (r_op)
      OP_MUL:                       w_fix_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_result = w_quo;
      default:                      w_fix_result = w_rem;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_MUL;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op   <= w_op;
            r_cnt  <= CNT_W'(ITERS);
            r_busy <= 1'b1;
            if (w_div_zero) begin
              // Preload the architectural answer: remainder = in1,
              // quotient = all ones.
              r_acc      <= {in1, {XLEN{1'b1}}};
              r_opnd     <= '0;
              r_neg_main <= 1'b0;
              r_neg_rem  <= 1'b0;
              r_state    <= ST_FIX;
            end else if (w_div_ovf) begin
              // Remainder = 0, quotient = in1.
              r_acc      <= {{XLEN{1'b0}}, in1};
              r_opnd     <= '0;
              r_neg_main <= 1'b0;
              r_neg_rem  <= 1'b0;
              r_state    <= ST_FIX;
            end else begin
              if (op_is_div(w_op)) begin
                r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                r_opnd <= w_mag_b;
              end else begin
                r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                r_opnd <= w_mag_a;
              end
              r_neg_main <= w_neg_a ^ w_neg_b;
              r_neg_rem  <= w_neg_a;
              r_state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_chain[STEPS];
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_result <= w_fix_result;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Three muldiv_unit instances (UNROLL = 1, 2, 4, XLEN = 32) with independent
// stimulus. Directed vectors, abort/reset/start-hold scenarios, and a random
// run compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s [3];
  logic        abort_s [3];
  logic [2:0]  op_s    [3];
  logic [31:0] in1_s   [3];
  logic [31:0] in2_s   [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [31:0] res_w   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    muldiv_unit #(
      .XLEN   (32),
      .UNROLL (1 << gi)
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start_s[gi]),
      .op     (op_s[gi]),
      .in1    (in1_s[gi]),
      .in2    (in2_s[gi]),
      .abort  (abort_s[gi]),
      .busy   (busy_w[gi]),
      .done   (done_w[gi]),
      .result (res_w[gi])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = longint'(signed'(a));
    longint      sb = longint'(signed'(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    int          qa = a;
    int          qb = b;
    logic [63:0] p;
    case (o)
      MUL:    begin p = ua * ub; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(qa / qb);
      end
      DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(qa % qb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (o >= DIV && b == 0) ||
           ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Called mid-cycle with the unit idle. Returns mid-cycle one clock after done,
  // so the next call starts in the cycle after done.
  task automatic do_op(input int idx, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string tag);
    int    lat = 0;
    int    exp_lat;
    string pfx;
    pfx     = $sformatf("u%0d_%s", 1 << idx, tag);
    exp_lat = is_special(o, a, b) ? 2 : (32 >> idx) + 2;
    op_s[idx]    = o;
    in1_s[idx]   = a;
    in2_s[idx]   = b;
    start_s[idx] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (c == 0) begin
        start_s[idx] = 1'b0;
        check_eq({pfx, "_busy"}, 64'(busy_w[idx]), 64'd1);
      end
      if (done_w[idx]) break;
    end
    check_eq({pfx, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({pfx, "_result"}, 64'(res_w[idx]), 64'(exp));
    check_eq({pfx, "_busy_at_done"}, 64'(busy_w[idx]), 64'd0);
    $display("u%0d %s op=%0d in1=%08h in2=%08h result=%08h lat=%0d",
             1 << idx, tag, o, a, b, res_w[idx], lat);
    @(posedge clk);
    #1;
    check_eq({pfx, "_done_pulse"}, 64'(done_w[idx]), 64'd0);
  endtask

  task automatic run_random(input int idx, input int count);
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;
    for (int n = 0; n < count; n++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel < 5) begin
        b = b >> $urandom_range(1, 31);
      end else if (sel < 7) begin
        a = a >> $urandom_range(1, 31);
      end
      do_op(idx, o, a, b, ref_model(o, a, b), "rnd");
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t dir_vec [12];

  initial begin
    int          ndone;
    logic [31:0] held_exp;

    dir_vec = '{
      '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
      '{MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
      '{MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
      '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{DIVU,   32'd100,        32'd7,         32'd14},
      '{REMU,   32'd100,        32'd7,         32'd2},
      '{DIVU,   32'd1234,       32'd0,         32'hFFFF_FFFF},
      '{REM,    32'd5,          32'd0,         32'd5},
      '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0}
    };

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      op_s[i]    = 3'd0;
      in1_s[i]   = 32'd0;
      in2_s[i]   = 32'd0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d_rst_busy", 1 << i), 64'(busy_w[i]), 64'd0);
      check_eq($sformatf("u%0d_rst_done", 1 << i), 64'(done_w[i]), 64'd0);
      check_eq($sformatf("u%0d_rst_result", 1 << i), 64'(res_w[i]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors on every unroll factor; the first start lands on the
    // first edge after reset release.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 12; k++) begin
        do_op(i, dir_vec[k].o, dir_vec[k].a, dir_vec[k].b, dir_vec[k].e,
              $sformatf("dir%0d", k));
      end
    end

    // Abort at CALC cycle 10
    do_op(0, MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "pre_abort");
    op_s[0] = DIVU; in1_s[0] = 32'd1000; in2_s[0] = 32'd3; start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort_s[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_s[0] = 1'b0;
    check_eq("u1_abort_busy", 64'(busy_w[0]), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done_w[0]) ndone++;
    end
    check_eq("u1_abort_no_done", 64'(ndone), 64'd0);
    check_eq("u1_abort_result", 64'(res_w[0]), 64'hFFFF_FFEB);
    $display("u1 abort at calc cycle 10 result=%08h", res_w[0]);

    // Abort wins over a simultaneous start
    op_s[0] = MUL; in1_s[0] = 32'd3; in2_s[0] = 32'd3;
    start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    check_eq("u1_abort_start_busy", 64'(busy_w[0]), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done_w[0]) ndone++;
    end
    check_eq("u1_abort_start_no_done", 64'(ndone), 64'd0);
    check_eq("u1_abort_start_result", 64'(res_w[0]), 64'hFFFF_FFEB);
    $display("u1 abort with start result=%08h", res_w[0]);

    // Start held high while busy, operands changed after capture
    held_exp = ref_model(MUL, 32'd12345, 32'd678);
    op_s[0] = MUL; in1_s[0] = 32'd12345; in2_s[0] = 32'd678; start_s[0] = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        in1_s[0] = 32'd999;
        in2_s[0] = 32'd5;
        op_s[0]  = DIVU;
      end
      if (c == 20) start_s[0] = 1'b0;
      if (done_w[0]) begin
        ndone = c;
        break;
      end
    end
    start_s[0] = 1'b0;
    check_eq("u1_hold_latency", 64'(ndone), 64'd34);
    check_eq("u1_hold_result", 64'(res_w[0]), 64'(held_exp));
    $display("u1 start-held op result=%08h lat=%0d", res_w[0], ndone);
    @(posedge clk);
    #1;

    // Reset asserted mid-CALC
    op_s[0] = DIV; in1_s[0] = 32'hFFFF_FC18; in2_s[0] = 32'd7; start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("u1_midrst_busy", 64'(busy_w[0]), 64'd0);
    check_eq("u1_midrst_done", 64'(done_w[0]), 64'd0);
    check_eq("u1_midrst_result", 64'(res_w[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done_w[0]) ndone++;
    end
    check_eq("u1_midrst_no_done", 64'(ndone), 64'd0);
    $display("u1 reset mid-calc result=%08h", res_w[0]);
    do_op(0, DIV, 32'hFFFF_FC18, 32'd7, ref_model(DIV, 32'hFFFF_FC18, 32'd7), "post_rst");

    // Random comparison against the reference model, all units in parallel
    fork
      run_random(0, 1650);
      run_random(1, 3050);
      run_random(2, 5300);
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
